// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP add/sub datapath among
// NUM_REQ requesters; one transaction in flight, response tagged with requester ID.
module fp_unit_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int FP_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_sub,
  output logic                   fpu_issue,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic                   fpu_sub,
  input  logic [31:0]            fpu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_data,
  output logic                   busy,
  output logic [15:0]            op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] scan_idx;
  logic            grant_vld;
  logic [3:0]      lat_cnt_q;
  logic [15:0]     op_cnt_q;

  // Search upward from the requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready = NUM_REQ'(1) << grant_id;
          state_d   = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= ID_W'(NUM_REQ - 1);
      id_q      <= '0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_sub   <= 1'b0;
      lat_cnt_q <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      op_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      // Operands go straight into the datapath-facing registers at grant, so
      // they are already valid during ISSUE and hold until the next grant.
      if (state_q == IDLE && grant_vld) begin
        rr_ptr_q <= grant_id;
        id_q     <= grant_id;
        fpu_a    <= req_a[32*grant_id +: 32];
        fpu_b    <= req_b[32*grant_id +: 32];
        fpu_sub  <= req_sub[grant_id];
      end
      if (state_q == ISSUE) lat_cnt_q <= 4'(FP_LATENCY - 1);
      if (state_q == WAIT) begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
        if (lat_cnt_q == '0) begin
          rsp_data <= fpu_result;
          rsp_id   <= id_q;
        end
      end
      if (state_q == RESP && rsp_ready) op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign fpu_issue = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign op_count  = op_cnt_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Scoreboard bench for fp_unit_arbiter: two instances (FP_LATENCY 1 and 3),
// behavioural FP datapath models, requester drivers and a response monitor.
module tb_fp_unit_arbiter;
  localparam int N = 4;
  localparam int LAT[2] = '{1, 3};
  localparam logic [31:0] OPA[4] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40800000};
  localparam logic [31:0] OPB[4] = '{32'h3F800000, 32'h40400000, 32'h3F000000, 32'h40800000};
  localparam logic        OPS[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  // 1+1=2, 2+3=5, 2-0.5=1.5, 4+4=8
  localparam logic [31:0] EXP[4] = '{32'h40000000, 32'h40A00000, 32'h3FC00000, 32'h41000000};

  typedef struct packed {logic k; logic [1:0] id; logic [31:0] d;} ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   rv[2], rr[2];
  logic [32*N-1:0] ra, rb;
  logic [N-1:0]   rs;
  logic           fi[2], fsub[2], rvld[2], rrdy[2], bsy[2];
  logic [31:0]    fa[2], fb[2], fres[2], rdat[2];
  logic [1:0]     rid[2];
  logic [15:0]    ocnt[2];

  int   ncmp = 0, nfail = 0, cyc = 0;
  int   n_pend[2][4];
  ent_t sbq[$];
  ent_t mon_e;
  logic [15:0] exp_cnt[2];
  int   acc_cyc[2], acc_id[2];
  logic pv[2], phs[2];
  logic [31:0] pdat[2];
  logic [1:0]  pid[2];
  logic [N-1:0] hs[2];
  logic [32:0] p1 = '0;
  logic [32:0] p3[3] = '{33'd0, 33'd0, 33'd0};

  fp_unit_arbiter #(.NUM_REQ(4), .ID_W(2), .FP_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]),
    .req_a(ra), .req_b(rb), .req_sub(rs), .fpu_issue(fi[0]), .fpu_a(fa[0]),
    .fpu_b(fb[0]), .fpu_sub(fsub[0]), .fpu_result(fres[0]), .rsp_valid(rvld[0]),
    .rsp_ready(rrdy[0]), .rsp_id(rid[0]), .rsp_data(rdat[0]), .busy(bsy[0]),
    .op_count(ocnt[0]));

  fp_unit_arbiter #(.NUM_REQ(4), .ID_W(2), .FP_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]),
    .req_a(ra), .req_b(rb), .req_sub(rs), .fpu_issue(fi[1]), .fpu_a(fa[1]),
    .fpu_b(fb[1]), .fpu_sub(fsub[1]), .fpu_result(fres[1]), .rsp_valid(rvld[1]),
    .rsp_ready(rrdy[1]), .rsp_id(rid[1]), .rsp_data(rdat[1]), .busy(bsy[1]),
    .op_count(ocnt[1]));

  // Datapath stand-in: known vectors only; the result is valid for exactly one
  // cycle, LAT cycles after the issue strobe, and garbage otherwise.
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic s);
    case ({s, a, b})
      {1'b0, 32'h3F800000, 32'h3F800000}: fpu_fn = 32'h40000000;
      {1'b0, 32'h40000000, 32'h40400000}: fpu_fn = 32'h40A00000;
      {1'b1, 32'h40000000, 32'h3F000000}: fpu_fn = 32'h3FC00000;
      {1'b0, 32'h40800000, 32'h40800000}: fpu_fn = 32'h41000000;
      default:                            fpu_fn = 32'h7FC00000;
    endcase
  endfunction

  always @(posedge clk) begin
    p1    <= {fi[0], fpu_fn(fa[0], fb[0], fsub[0])};
    p3[0] <= {fi[1], fpu_fn(fa[1], fb[1], fsub[1])};
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign fres[0] = p1[32]    ? p1[31:0]    : 32'hDEADBEEF;
  assign fres[1] = p3[2][32] ? p3[2][31:0] : 32'hDEADBEEF;

  always_comb begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        rv[k][i] = (n_pend[k][i] != 0);
  end

  // Requesters hold valid until they see req_ready, then retire one request.
  always begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) hs[k] = rr[k] & rv[k];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        if (hs[k][i] && n_pend[k][i] > 0) n_pend[k][i]--;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input int id);
    ent_t e;
    e.k  = 1'(k);
    e.id = 2'(id);
    e.d  = EXP[id];
    sbq.push_back(e);
  endtask

  task automatic wait_done(input int k, input int budget);
    int t = 0;
    bit done = 0;
    while (!done && t < budget) begin
      @(negedge clk);
      #1;
      t++;
      done = (sbq.size() == 0) && !bsy[k] && (n_pend[k][0] + n_pend[k][1] + n_pend[k][2] + n_pend[k][3] == 0);
    end
    chk($sformatf("u%0d_done_in_budget", k), 32'(done), 32'd1);
  endtask

  task automatic wait_sig(input int k, input bit want_issue, input int budget);
    int t = 0;
    bit seen = 0;
    while (!seen && t < budget) begin
      @(negedge clk);
      t++;
      seen = want_issue ? fi[k] : rvld[k];
    end
    chk($sformatf("u%0d_%s_seen", k, want_issue ? "issue" : "rsp"), 32'(seen), 32'd1);
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        pv[k]  = 1'b0;
        phs[k] = 1'b0;
      end else begin
        if (rr[k] != 0 || bsy[k])
          chk($sformatf("u%0d_req_ready_count", k), 32'($countones(rr[k])), bsy[k] ? 32'd0 : 32'd1);
        for (int i = 0; i < N; i++)
          if (rr[k][i] && rv[k][i]) begin
            acc_cyc[k] = cyc;
            acc_id[k]  = i;
          end
        if (fi[k]) begin
          chk($sformatf("u%0d_issue_lat", k), 32'(cyc - acc_cyc[k]), 32'd1);
          chk($sformatf("u%0d_fpu_a", k), fa[k], OPA[acc_id[k]]);
          chk($sformatf("u%0d_fpu_b", k), fb[k], OPB[acc_id[k]]);
          chk($sformatf("u%0d_fpu_sub", k), 32'(fsub[k]), 32'(OPS[acc_id[k]]));
        end
        if (rvld[k] && !pv[k])
          chk($sformatf("u%0d_rsp_lat", k), 32'(cyc - acc_cyc[k]), 32'(LAT[k] + 2));
        if (rvld[k] && pv[k] && !phs[k]) begin
          chk($sformatf("u%0d_hold_data", k), rdat[k], pdat[k]);
          chk($sformatf("u%0d_hold_id", k), 32'(rid[k]), 32'(pid[k]));
        end
        if (phs[k]) chk($sformatf("u%0d_rsp_valid_drop", k), 32'(rvld[k]), 32'd0);
        if (rvld[k] && rrdy[k]) begin
          if (sbq.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL u%0d_unexpected_rsp: got id %0d data %0h, expected no response", k, rid[k], rdat[k]);
          end else begin
            mon_e = sbq.pop_front();
            chk($sformatf("u%0d_sb_inst", k), 32'(k), 32'(mon_e.k));
            chk($sformatf("u%0d_rsp_id", k), 32'(rid[k]), 32'(mon_e.id));
            chk($sformatf("u%0d_rsp_data", k), rdat[k], mon_e.d);
            chk($sformatf("u%0d_op_count", k), 32'(ocnt[k]), 32'(exp_cnt[k]));
            exp_cnt[k] = exp_cnt[k] + 16'd1;
          end
        end
        pv[k]   = rvld[k];
        phs[k]  = rvld[k] && rrdy[k];
        pdat[k] = rdat[k];
        pid[k]  = rid[k];
      end
    end
  end

  task automatic check_reset_state(input int k);
    chk($sformatf("u%0d_rst_req_ready", k), 32'(rr[k]), 32'd0);
    chk($sformatf("u%0d_rst_fpu_issue", k), 32'(fi[k]), 32'd0);
    chk($sformatf("u%0d_rst_fpu_a", k), fa[k], 32'd0);
    chk($sformatf("u%0d_rst_fpu_b", k), fb[k], 32'd0);
    chk($sformatf("u%0d_rst_fpu_sub", k), 32'(fsub[k]), 32'd0);
    chk($sformatf("u%0d_rst_rsp_valid", k), 32'(rvld[k]), 32'd0);
    chk($sformatf("u%0d_rst_rsp_id", k), 32'(rid[k]), 32'd0);
    chk($sformatf("u%0d_rst_rsp_data", k), rdat[k], 32'd0);
    chk($sformatf("u%0d_rst_busy", k), 32'(bsy[k]), 32'd0);
    chk($sformatf("u%0d_rst_op_count", k), 32'(ocnt[k]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ra[32*i +: 32] = OPA[i];
      rb[32*i +: 32] = OPB[i];
      rs[i]          = OPS[i];
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) n_pend[k][i] = 0;
      rrdy[k]    = 1'b1;
      exp_cnt[k] = 16'd0;
    end
    repeat (2) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    @(posedge clk); #1 reset = 1'b0;

    // Single request, latency 1: requester 2, 2.0 - 0.5
    push_exp(0, 2);
    n_pend[0][2] = 1;
    wait_done(0, 50);
    chk("u0_single_op_count", 32'(ocnt[0]), 32'd1);

    // Round robin on the latency-3 unit, pointer fresh from reset
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) push_exp(1, j % 4);
    for (int i = 0; i < N; i++) n_pend[1][i] = 2;
    wait_done(1, 200);

    // Latency 3: requester 1, 2.0 + 3.0
    @(posedge clk); #1;
    push_exp(1, 1);
    n_pend[1][1] = 1;
    wait_done(1, 50);
    chk("u1_op_count_after_9", 32'(ocnt[1]), 32'd9);

    // Backpressure: response held 5 cycles while another requester waits
    @(posedge clk); #1;
    rrdy[0] = 1'b0;
    push_exp(0, 0);
    push_exp(0, 3);
    n_pend[0][0] = 1;
    wait_sig(0, 1'b0, 50);
    @(posedge clk); #1;
    n_pend[0][3] = 1;
    repeat (4) begin
      @(negedge clk);
      chk("u0_bp_req_ready", 32'(rr[0]), 32'd0);
      chk("u0_bp_rsp_valid", 32'(rvld[0]), 32'd1);
    end
    @(posedge clk); #1 rrdy[0] = 1'b1;
    wait_done(0, 50);
    chk("u0_bp_op_count", 32'(ocnt[0]), 32'd3);

    // op_count wrap, counter preloaded near the top
    @(posedge clk); #1;
    force u_l1.op_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release u_l1.op_cnt_q;
    exp_cnt[0] = 16'hFFFE;
    chk("u0_preload", 32'(ocnt[0]), 32'h0000FFFE);
    push_exp(0, 0);
    push_exp(0, 1);
    n_pend[0][0] = 1;
    n_pend[0][1] = 1;
    wait_done(0, 50);
    chk("u0_op_count_wrap", 32'(ocnt[0]), 32'd0);

    // Reset during WAIT: the in-flight op must vanish without a response
    @(posedge clk); #1;
    n_pend[1][1] = 1;
    wait_sig(1, 1'b1, 50);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("u1_midrst_busy", 32'(bsy[1]), 32'd0);
    chk("u1_midrst_op_count", 32'(ocnt[1]), 32'd0);
    chk("u1_midrst_rsp_valid", 32'(rvld[1]), 32'd0);
    chk("u0_midrst_op_count", 32'(ocnt[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    for (int i = 0; i < N; i++) n_pend[1][i] = 0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    push_exp(1, 3);
    n_pend[1][3] = 1;
    wait_done(1, 50);
    chk("u1_after_rst_op_count", 32'(ocnt[1]), 32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one fixed-latency floating-point add/sub datapath among NUM_REQ requesters.
- Round-robin arbitration, one transaction in flight at a time.
- Issues operands to the datapath, counts its latency, captures the result and returns it tagged with the requester ID over a valid/ready response port.
- Sits between the core's FP issue logic and the FP add/sub unit.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID, equal to clog2(NUM_REQ)
FP_LATENCY, 1, cycles from the datapath sampling operands to the result being valid on fpu_result (1..8)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle
req_a  input  32*NUM_REQ  operand A per requester, IEEE-754 single; requester i occupies bits [32i+31:32i]
req_b  input  32*NUM_REQ  operand B per requester, same packing
req_sub  input  NUM_REQ  1 = A-B, 0 = A+B
fpu_issue  output  1  one-cycle strobe: operands valid for datapath
fpu_a  output  32  operand A to datapath
fpu_b  output  32  operand B to datapath
fpu_sub  output  1  operation select to datapath
fpu_result  input  32  datapath result
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  requester that owns the response
rsp_data  output  32  result word
busy  output  1  high in any state other than IDLE
op_count  output  16  completed responses, wraps 0xFFFF->0

Behaviour:
- Reset (asynchronous): state=IDLE; rr_ptr=NUM_REQ-1. All outputs are 0: req_ready, fpu_issue, fpu_a, fpu_b, fpu_sub, rsp_valid, rsp_id, rsp_data, busy, op_count.
- Requester rule: hold req_valid and operands stable until req_ready is seen; dropping valid early is not supported.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant the first asserted req_valid, searching from rr_ptr+1 upward, modulo NUM_REQ.
  - req_ready[g] is high combinationally in the same cycle.
  - On that edge: latch A, B, sub and g; set rr_ptr=g; go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE: exactly 1 cycle.
  - fpu_issue=1; fpu_a, fpu_b, fpu_sub come from the latches, are registered, and stay stable until the next ISSUE.
  - Load lat_cnt=FP_LATENCY-1; go to WAIT.
- WAIT: lasts FP_LATENCY cycles.
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0: capture fpu_result into rsp_data and the latched g into rsp_id; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable while rsp_ready is low.
  - On rsp_valid&rsp_ready: rsp_valid drops next cycle, op_count increments, go to IDLE.
- Timing with rsp_ready tied high: req_ready to rsp_valid is FP_LATENCY+2 cycles. Back-to-back throughput is one op per FP_LATENCY+3 cycles.
- req_ready is 0 outside IDLE. New requests are never accepted while a transaction is in flight.
- Fairness: after a grant to requester g, g has the lowest priority in the next arbitration. With all requesters continuously valid, the grant order is 0,1,2,...,NUM_REQ-1,0,...
- Reset mid-operation: the in-flight transaction is discarded with no response. Any late fpu_result is ignored.
- No inspection or modification of FP values: NaN, Inf and denormal handling belong to the datapath.

Test Plan:
- Single request, FP_LATENCY=1:
  - Stimulus: requester 2 with A=0x40000000, B=0x3F000000, sub=1; bench FPU model returns 0x3FC00000.
  - Required: req_ready[2] 1 cycle; fpu_issue 1 cycle later with the same operands; rsp_valid 3 cycles after accept; rsp_id=2; rsp_data=0x3FC00000; op_count=1.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously for 8 transactions.
  - Required: rsp_id sequence 0,1,2,3,0,1,2,3; never two req_ready bits high at once.
- Backpressure:
  - Stimulus: rsp_ready low for 5 cycles during RESP.
  - Required: rsp_valid, rsp_data and rsp_id stable all 5 cycles; req_ready stays 0; completion occurs in the cycle rsp_ready rises.
- Latency parameter:
  - Stimulus: FP_LATENCY=3, requester 1 with A=0x40000000, B=0x40400000, sub=0; FPU model returns 0x40A00000.
  - Required: result captured exactly 3 cycles after fpu_issue; rsp_valid 5 cycles after accept.
- Reset mid-WAIT:
  - Stimulus: assert reset during WAIT, then present requester 3.
  - Required: no rsp_valid for the dropped op; busy=0, op_count=0; the next grant goes to the lowest-indexed valid requester (3 here), response correct.
- op_count wrap:
  - Stimulus: preload via 65536 transactions in an accelerated sim.
  - Required: op_count wraps 0xFFFF->0x0000.
